// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver with 3-sample majority voting,
// framing/parity error flags and a valid/ready output with overrun detection.
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 rx_i,
    input  logic                 ready_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    output logic                 frame_err_o,
    output logic                 parity_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);
    localparam int MID = CLKS_PER_BIT / 2;
    localparam int TW  = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] T_S0 = TW'(MID - 1), T_S1 = TW'(MID), T_DEC = TW'(MID + 1), T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1), LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {WAIT_HIGH, IDLE, START, DATA, PAR, STOP} state_t;
    state_t state, state_n;
    logic rx_m, rx_s, smp0, smp1, maj, dec, wrap, done, ferr_n, ferr, perr;
    logic [TW-1:0] timer;
    logic [3:0] bit_cnt;
    logic [DATA_BITS-1:0] shreg;

    assign dec    = timer == T_DEC;
    assign wrap   = timer == T_LAST;
    assign maj    = (smp0 & smp1) | (smp0 & rx_s) | (smp1 & rx_s);
    assign ferr_n = ferr | ~maj;

    always_ff @(posedge clk) state <= !resetn ? WAIT_HIGH : state_n;

    always_comb begin
        state_n = state;
        done    = 1'b0;
        case (state)
            WAIT_HIGH: if (rx_s) state_n = IDLE;
            IDLE:      if (!rx_s) state_n = START;
            START:     if (dec && maj) state_n = IDLE; else if (wrap) state_n = DATA;
            DATA:      if (wrap && bit_cnt == LAST_DATA) state_n = PARITY != 0 ? PAR : STOP;
            PAR:       if (wrap) state_n = STOP;
            STOP: if (dec && bit_cnt == LAST_STOP) begin
                done    = 1'b1;
                // a low line after a framing error is a break: wait for idle before re-arming
                state_n = (ferr_n && !rx_s) ? WAIT_HIGH : IDLE;
            end
            default:   state_n = WAIT_HIGH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_m         <= 1'b0;
            rx_s         <= 1'b0;
            timer        <= '0;
            bit_cnt      <= '0;
            smp0         <= 1'b0;
            smp1         <= 1'b0;
            shreg        <= '0;
            ferr         <= 1'b0;
            perr         <= 1'b0;
            busy_o       <= 1'b0;
            data_o       <= '0;
            valid_o      <= 1'b0;
            frame_err_o  <= 1'b0;
            parity_err_o <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            rx_m    <= rx_i;
            rx_s    <= rx_m;
            timer   <= (state_n == IDLE || state_n == WAIT_HIGH || wrap) ? '0 : timer + 1'b1;
            busy_o  <= state_n != IDLE && state_n != WAIT_HIGH;
            if (timer == T_S0) smp0 <= rx_s;
            if (timer == T_S1) smp1 <= rx_s;
            if (state == IDLE) begin
                bit_cnt <= '0;
                ferr    <= 1'b0;
                perr    <= 1'b0;
            end else if (wrap) bit_cnt <= (state_n != state) ? '0 : bit_cnt + 1'b1;
            if (dec && state == DATA) shreg <= {maj, shreg[DATA_BITS-1:1]};
            if (dec && state == PAR) perr <= ^shreg ^ maj ^ (PARITY == 1);
            if (dec && state == STOP && !maj) ferr <= 1'b1;
            if (done && (!valid_o || ready_i)) begin
                data_o       <= shreg;
                frame_err_o  <= ferr_n;
                parity_err_o <= perr;
            end
            valid_o   <= done || (valid_o && !ready_i);
            overrun_o <= (valid_o && ready_i) ? 1'b0 : (overrun_o || (done && valid_o));
        end
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed bench for an 8N1 and a 7E2 receiver at 16 clocks per bit.
module tb_uart_rx_cfg;
    logic clk = 0, resetn = 0, rx_a = 1, rx_b = 1, ready_a = 1, ready_b = 1;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic valid_a, ferr_a, perr_a, ovr_a, busy_a, valid_b, ferr_b, perr_b, ovr_b, busy_b;
    int cyc = 0, checks = 0, errors = 0;
    int vcnt_a = 0, vrise_a = -1, brise_a = -1, bfall_a = -1, bcnt_a = 0, vcnt_b = 0, vrise_b = -1;
    logic [7:0] cap_data_a = 0;
    logic [6:0] cap_data_b = 0;
    logic cap_ferr_a = 0, cap_perr_a = 0, cap_ovr_a = 0, cap_ferr_b = 0, cap_perr_b = 0;
    logic pv_a = 0, pb_a = 0, pv_b = 0;

    uart_rx_cfg #(.CLKS_PER_BIT(16)) u_a (
        .clk(clk), .resetn(resetn), .rx_i(rx_a), .ready_i(ready_a), .data_o(data_a), .valid_o(valid_a),
        .frame_err_o(ferr_a), .parity_err_o(perr_a), .overrun_o(ovr_a), .busy_o(busy_a)
    );
    uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_b (
        .clk(clk), .resetn(resetn), .rx_i(rx_b), .ready_i(ready_b), .data_o(data_b), .valid_o(valid_b),
        .frame_err_o(ferr_b), .parity_err_o(perr_b), .overrun_o(ovr_b), .busy_o(busy_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_a) begin
            vcnt_a++;
            cap_data_a = data_a;
            cap_ferr_a = ferr_a;
            cap_perr_a = perr_a;
            cap_ovr_a  = ovr_a;
        end
        if (valid_a && !pv_a) vrise_a = cyc;
        if (busy_a && !pb_a) begin
            brise_a = cyc;
            bcnt_a++;
        end
        if (!busy_a && pb_a) bfall_a = cyc;
        if (valid_b) begin
            vcnt_b++;
            cap_data_b = data_b;
            cap_ferr_b = ferr_b;
            cap_perr_b = perr_b;
        end
        if (valid_b && !pv_b) vrise_b = cyc;
        pv_a = valid_a;
        pb_a = busy_a;
        pv_b = valid_b;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit b, input logic v);
        if (b) rx_b = v; else rx_a = v;
    endtask

    // frame bits LSB first; bit g (if >= 0) gets a 1-cycle inverted pulse at its middle
    task automatic send(input bit b, input logic [15:0] fr, input int n, input int g, output int t0);
        @(posedge clk); #1;
        t0 = cyc;
        for (int i = 0; i < n; i++) begin
            drive(b, fr[i]);
            if (i == g) begin
                repeat (8) @(posedge clk);
                #1 drive(b, ~fr[i]);
                @(posedge clk);
                #1 drive(b, fr[i]);
                repeat (7) @(posedge clk);
                #1;
            end else begin
                repeat (16) @(posedge clk);
                #1;
            end
        end
        drive(b, 1'b1);
    endtask

    initial begin
        int t0, n0, c0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_data_a", 32'(data_a), 0);
        check("rst_flags_a", 32'({valid_a, ferr_a, perr_a, ovr_a, busy_a}), 0);
        check("rst_b", 32'({valid_b, ferr_b, perr_b, ovr_b, busy_b, data_b}), 0);
        resetn = 1;
        repeat (6) @(posedge clk);

        n0 = vcnt_a;
        send(0, {6'h0, 1'b1, 8'hA5, 1'b0}, 10, -1, t0);
        repeat (4) @(posedge clk);
        #1;
        check("a5_data", 32'(cap_data_a), 'hA5);
        check("a5_flags", 32'({cap_ferr_a, cap_perr_a, cap_ovr_a}), 0);
        check("a5_vrise", vrise_a, t0 + 156);
        check("a5_vcnt", vcnt_a - n0, 1);
        check("a5_bfall", bfall_a, t0 + 156);

        n0 = vcnt_b;
        send(1, {4'h0, 2'b11, 1'b0, 7'h35, 1'b0}, 11, -1, t0);
        repeat (4) @(posedge clk);
        #1;
        check("e2_data", 32'(cap_data_b), 'h35);
        check("e2_flags", 32'({cap_ferr_b, cap_perr_b}), 0);
        check("e2_vrise", vrise_b, t0 + 172);
        check("e2_vcnt", vcnt_b - n0, 1);
        send(1, {4'h0, 2'b11, 1'b1, 7'h35, 1'b0}, 11, -1, t0);
        repeat (4) @(posedge clk);
        #1;
        check("e2bad_data", 32'(cap_data_b), 'h35);
        check("e2bad_flags", 32'({cap_ferr_b, cap_perr_b}), 1);

        n0 = vcnt_a;
        @(posedge clk);
        #1 rx_a = 0;
        t0 = cyc;
        repeat (3) @(posedge clk);
        #1 rx_a = 1;
        repeat (30) @(posedge clk);
        #1;
        check("glitch_brise", brise_a, t0 + 3);
        check("glitch_bfall", bfall_a, t0 + 12);
        check("glitch_vcnt", vcnt_a - n0, 0);

        send(0, {6'h0, 1'b1, 8'hA5, 1'b0}, 10, 2, t0);
        repeat (4) @(posedge clk);
        #1;
        check("maj_data", 32'(cap_data_a), 'hA5);

        ready_a = 0;
        send(0, {6'h0, 1'b1, 8'h11, 1'b0}, 10, -1, t0);
        repeat (4) @(posedge clk);
        #1;
        check("ovr_first", 32'({valid_a, ovr_a, data_a}), 'h211);
        send(0, {6'h0, 1'b1, 8'h22, 1'b0}, 10, -1, t0);
        repeat (4) @(posedge clk);
        #1;
        check("ovr_hold", 32'({valid_a, ovr_a, data_a}), 'h311);
        @(posedge clk);
        #1 ready_a = 1;
        @(posedge clk);
        #1 ready_a = 0;
        check("ovr_clear", 32'({valid_a, ovr_a}), 0);

        ready_a = 1;
        n0 = vcnt_a;
        c0 = bcnt_a;
        @(posedge clk);
        #1 rx_a = 0;
        t0 = cyc;
        repeat (480) @(posedge clk);
        #1;
        check("brk_vcnt", vcnt_a - n0, 1);
        check("brk_word", 32'({cap_ferr_a, cap_data_a}), 'h100);
        check("brk_vrise", vrise_a, t0 + 156);
        check("brk_starts", bcnt_a - c0, 1);
        check("brk_busy", 32'(busy_a), 0);
        rx_a = 1;
        repeat (20) @(posedge clk);
        send(0, {6'h0, 1'b1, 8'h5A, 1'b0}, 10, -1, t0);
        repeat (4) @(posedge clk);
        #1;
        check("brk_after", 32'({cap_ferr_a, cap_data_a}), 'h5A);

        n0 = vcnt_a;
        c0 = bcnt_a;
        @(posedge clk);
        #1 rx_a = 0;
        repeat (70) @(posedge clk);
        #1 resetn = 0;
        repeat (3) @(posedge clk);
        #1;
        check("mrst_out", 32'({valid_a, ferr_a, perr_a, ovr_a, busy_a, data_a}), 0);
        resetn = 1;
        repeat (40) @(posedge clk);
        #1;
        check("mrst_idle", 32'(busy_a), 0);
        check("mrst_vcnt", vcnt_a - n0, 0);
        check("mrst_starts", bcnt_a - c0, 1);
        rx_a = 1;
        repeat (5) @(posedge clk);
        send(0, {6'h0, 1'b1, 8'hC3, 1'b0}, 10, -1, t0);
        repeat (4) @(posedge clk);
        #1;
        check("mrst_next", 32'({cap_ferr_a, cap_perr_a, cap_data_a}), 'hC3);
        check("mrst_vrise", vrise_a, t0 + 156);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
